// File: rtl/sonar_pkg.sv
// Shared definitions for the ultrasonic ranging blocks: FSM encoding,
// counter width and cycle-count derivation from the time parameters.
package sonar_pkg;

    localparam int unsigned CNT_W = 24;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_TRIG = 3'd1;
    localparam logic [2:0] ST_ARM  = 3'd2;
    localparam logic [2:0] ST_ECHO = 3'd3;
    localparam logic [2:0] ST_HOLD = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_TRIG = ST_TRIG,
        S_ARM  = ST_ARM,
        S_ECHO = ST_ECHO,
        S_HOLD = ST_HOLD
    } state_t;

    function automatic logic [CNT_W-1:0] trig_cyc(input int unsigned mhz, input int unsigned us);
        return CNT_W'(mhz * us);
    endfunction

    function automatic logic [CNT_W-1:0] to_cyc(input int unsigned mhz, input int unsigned ms);
        return CNT_W'(mhz * ms * 32'd1000);
    endfunction

    function automatic logic [CNT_W-1:0] per_cyc(input int unsigned mhz, input int unsigned ms);
        return CNT_W'(mhz * ms * 32'd1000);
    endfunction

    // Subtract without wrapping below zero.
    function automatic logic [CNT_W-1:0] floor_sub(input logic [CNT_W-1:0] v,
                                                   input logic [CNT_W-1:0] d);
        return (v > d) ? v - d : '0;
    endfunction

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchronizer for an asynchronous pin, with single-cycle
// rise/fall strobes derived from the synchronized level and its delay.
module echo_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise_c,
    output logic fall_c
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise_c = sync & ~prev;
    assign fall_c = ~sync & prev;

endmodule

// File: rtl/sonar_trigger_tx.sv
// Ultrasonic sensor transmit side: fixed-width trigger pulse, echo window
// supervision with timeout, and minimum ranging period enforcement.
module sonar_trigger_tx
    import sonar_pkg::*;
#(
    parameter int unsigned CLKSPDMHZ = 100,
    parameter int unsigned TRIGUS    = 10,
    parameter int unsigned TIMEOUTMS = 38,
    parameter int unsigned PERIODMS  = 60
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic continuous,
    input  logic echo,
    output logic trig,
    output logic busy,
    output logic echo_rise,
    output logic done,
    output logic timeout
);

    localparam logic [CNT_W-1:0] TRIG_CYC = trig_cyc(CLKSPDMHZ, TRIGUS);
    localparam logic [CNT_W-1:0] TO_CYC   = to_cyc(CLKSPDMHZ, TIMEOUTMS);
    localparam logic [CNT_W-1:0] PER_CYC  = per_cyc(CLKSPDMHZ, PERIODMS);

    // Outputs trail the state by one register stage, and IDLE spends one
    // sampling cycle, so HOLD leaves two counts early to keep trig
    // rise-to-rise spacing at exactly PER_CYC.
    localparam logic [CNT_W-1:0] TRIG_LIM = floor_sub(TRIG_CYC, CNT_W'(1));
    localparam logic [CNT_W-1:0] HOLD_LIM = floor_sub(PER_CYC, CNT_W'(2));

    state_t           state;
    logic [CNT_W-1:0] ph_cnt;
    logic [CNT_W-1:0] per_cnt;
    logic             rise_c;
    logic             fall_c;

    echo_sync u_echo_sync (
        .clk    (clk),
        .reset  (reset),
        .din    (echo),
        .rise_c (rise_c),
        .fall_c (fall_c)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            ph_cnt    <= '0;
            per_cnt   <= '0;
            trig      <= 1'b0;
            busy      <= 1'b0;
            echo_rise <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            echo_rise <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            trig      <= (state == S_TRIG);
            busy      <= (state != S_IDLE);
            per_cnt   <= per_cnt + CNT_W'(1);

            case (state)
                S_IDLE: begin
                    ph_cnt  <= '0;
                    per_cnt <= '0;
                    if (start || continuous) begin
                        state <= S_TRIG;
                    end
                end
                S_TRIG: begin
                    if (ph_cnt >= TRIG_LIM) begin
                        ph_cnt <= '0;
                        state  <= S_ARM;
                    end else begin
                        ph_cnt <= ph_cnt + CNT_W'(1);
                    end
                end
                // Only a fresh 0->1 edge counts; a level already high is stale.
                S_ARM: begin
                    ph_cnt <= ph_cnt + CNT_W'(1);
                    if (rise_c) begin
                        echo_rise <= 1'b1;
                        state     <= S_ECHO;
                    end else if (ph_cnt >= TO_CYC) begin
                        timeout <= 1'b1;
                        state   <= S_HOLD;
                    end
                end
                // A falling edge on the expiry cycle is a valid echo.
                S_ECHO: begin
                    ph_cnt <= ph_cnt + CNT_W'(1);
                    if (fall_c) begin
                        done  <= 1'b1;
                        state <= S_HOLD;
                    end else if (ph_cnt >= TO_CYC) begin
                        timeout <= 1'b1;
                        state   <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (per_cnt >= HOLD_LIM) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sonar_trigger_tx.sv
// Scoreboard bench for sonar_trigger_tx: expected output events are queued
// with each stimulus and compared against events captured from the pins.
module tb_sonar_trigger_tx;

    localparam int unsigned TRIG_CYC = 10;
    localparam int unsigned TO_CYC   = 2000;
    localparam int unsigned PER_CYC  = 3000;

    localparam logic [2:0] EV_TRIG_RISE = 3'd1;
    localparam logic [2:0] EV_TRIG_FALL = 3'd2;
    localparam logic [2:0] EV_BUSY_FALL = 3'd3;
    localparam logic [2:0] EV_ECHO_RISE = 3'd4;
    localparam logic [2:0] EV_DONE      = 3'd5;
    localparam logic [2:0] EV_TIMEOUT   = 3'd6;

    typedef struct packed {
        logic [2:0]  kind;
        logic [31:0] at;
    } ev_t;

    logic clk        = 1'b0;
    logic reset      = 1'b0;
    logic start      = 1'b0;
    logic continuous = 1'b0;
    logic echo       = 1'b0;
    logic trig;
    logic busy;
    logic echo_rise;
    logic done;
    logic timeout;

    int unsigned cyc   = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    ev_t         exp_q[$];
    ev_t         obs_q[$];
    logic        trig_q = 1'b0;
    logic        busy_q = 1'b0;

    sonar_trigger_tx #(
        .CLKSPDMHZ (1),
        .TRIGUS    (10),
        .TIMEOUTMS (2),
        .PERIODMS  (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .continuous (continuous),
        .echo       (echo),
        .trig       (trig),
        .busy       (busy),
        .echo_rise  (echo_rise),
        .done       (done),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event capture, sampled mid-cycle; 'at' is the edge that produced it.
    always @(negedge clk) begin
        if (trig === 1'b1 && trig_q !== 1'b1) obs_q.push_back('{kind: EV_TRIG_RISE, at: cyc});
        if (trig === 1'b0 && trig_q === 1'b1) obs_q.push_back('{kind: EV_TRIG_FALL, at: cyc});
        if (busy === 1'b0 && busy_q === 1'b1) obs_q.push_back('{kind: EV_BUSY_FALL, at: cyc});
        if (echo_rise === 1'b1) obs_q.push_back('{kind: EV_ECHO_RISE, at: cyc});
        if (done === 1'b1)      obs_q.push_back('{kind: EV_DONE, at: cyc});
        if (timeout === 1'b1)   obs_q.push_back('{kind: EV_TIMEOUT, at: cyc});
        trig_q = trig;
        busy_q = busy;
    end

    function automatic void expect_ev(input logic [2:0] k, input int unsigned t);
        exp_q.push_back('{kind: k, at: t});
    endfunction

    task automatic wait_until(input int unsigned e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [4:0] v;
        string      nm [5] = '{"timeout", "done", "echo_rise", "busy", "trig"};
        reset = 1'b0;
        repeat (3) @(negedge clk);
        v = {trig, busy, echo_rise, done, timeout};
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (v[i] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_%s: observed %b expected 0", nm[i], v[i]);
            end
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single_shot;
        int unsigned n;
        ev_t e, o;
        @(negedge clk);
        exp_q.delete(); obs_q.delete();
        n = cyc + 1;
        start = 1'b1;
        expect_ev(EV_TRIG_RISE, n + 1);
        expect_ev(EV_TRIG_FALL, n + 1 + TRIG_CYC);
        expect_ev(EV_ECHO_RISE, n + 98);
        expect_ev(EV_DONE,      n + 598);
        expect_ev(EV_BUSY_FALL, n + PER_CYC);
        wait_until(n);       start = 1'b0;
        wait_until(n + 95);  echo = 1'b1;
        wait_until(n + 595); echo = 1'b0;
        wait_until(n + PER_CYC + 10);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                o = obs_q.pop_front(); n_bad++;
                $display("FAIL single_shot: unexpected event kind=%0d at=%0d", o.kind, o.at);
            end else if (obs_q.size() == 0) begin
                e = exp_q.pop_front(); n_bad++;
                $display("FAIL single_shot: missing event kind=%0d at=%0d", e.kind, e.at);
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL single_shot: observed kind=%0d at=%0d expected kind=%0d at=%0d",
                             o.kind, o.at, e.kind, e.at);
                end
            end
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_shot_idle: busy observed %b expected 0", busy);
        end
    endtask

    task automatic test_no_echo(input logic stuck);
        int unsigned n;
        ev_t e, o;
        @(negedge clk);
        if (stuck) begin
            echo = 1'b1;
            repeat (6) @(negedge clk);
        end
        exp_q.delete(); obs_q.delete();
        n = cyc + 1;
        start = 1'b1;
        expect_ev(EV_TRIG_RISE, n + 1);
        expect_ev(EV_TRIG_FALL, n + 1 + TRIG_CYC);
        expect_ev(EV_TIMEOUT,   n + 1 + TRIG_CYC + TO_CYC);
        expect_ev(EV_BUSY_FALL, n + PER_CYC);
        wait_until(n); start = 1'b0;
        // A late fall while holding must not produce a measurement.
        wait_until(n + 2500); echo = 1'b0;
        wait_until(n + PER_CYC + 10);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                o = obs_q.pop_front(); n_bad++;
                $display("FAIL no_echo(stuck=%0d): unexpected event kind=%0d at=%0d", stuck, o.kind, o.at);
            end else if (obs_q.size() == 0) begin
                e = exp_q.pop_front(); n_bad++;
                $display("FAIL no_echo(stuck=%0d): missing event kind=%0d at=%0d", stuck, e.kind, e.at);
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL no_echo(stuck=%0d): observed kind=%0d at=%0d expected kind=%0d at=%0d",
                             stuck, o.kind, o.at, e.kind, e.at);
                end
            end
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL no_echo_idle: busy observed %b expected 0", busy);
        end
    endtask

    task automatic test_continuous;
        int unsigned n;
        ev_t e, o;
        @(negedge clk);
        exp_q.delete(); obs_q.delete();
        n = cyc + 1;
        continuous = 1'b1;
        for (int k = 0; k < 4; k++) begin
            expect_ev(EV_TRIG_RISE, n + k * PER_CYC + 1);
            expect_ev(EV_TRIG_FALL, n + k * PER_CYC + 1 + TRIG_CYC);
            expect_ev(EV_TIMEOUT,   n + k * PER_CYC + 1 + TRIG_CYC + TO_CYC);
            expect_ev(EV_BUSY_FALL, n + (k + 1) * PER_CYC);
        end
        // Requests while busy must be dropped, not queued.
        wait_until(n + 500);  start = 1'b1;
        wait_until(n + 501);  start = 1'b0;
        wait_until(n + 3500); start = 1'b1;
        wait_until(n + 3502); start = 1'b0;
        wait_until(n + 9999); continuous = 1'b0;
        wait_until(n + 4 * PER_CYC + 10);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                o = obs_q.pop_front(); n_bad++;
                $display("FAIL continuous: unexpected event kind=%0d at=%0d", o.kind, o.at);
            end else if (obs_q.size() == 0) begin
                e = exp_q.pop_front(); n_bad++;
                $display("FAIL continuous: missing event kind=%0d at=%0d", e.kind, e.at);
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL continuous: observed kind=%0d at=%0d expected kind=%0d at=%0d",
                             o.kind, o.at, e.kind, e.at);
                end
            end
        end
    endtask

    task automatic test_reset_mid_trig;
        int unsigned n;
        ev_t e, o;
        @(negedge clk);
        exp_q.delete(); obs_q.delete();
        n = cyc + 1;
        start = 1'b1;
        expect_ev(EV_TRIG_RISE, n + 1);
        expect_ev(EV_TRIG_FALL, n + 4);
        expect_ev(EV_BUSY_FALL, n + 4);
        wait_until(n);     start = 1'b0;
        wait_until(n + 2); echo = 1'b1;
        wait_until(n + 3); reset = 1'b0;
        wait_until(n + 4);
        n_cmp++;
        if ({trig, busy, echo_rise, done, timeout} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_mid_trig_outputs: observed %b expected 00000",
                     {trig, busy, echo_rise, done, timeout});
        end
        reset = 1'b1;
        wait_until(n + 200); echo = 1'b0;
        wait_until(n + 3500);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                o = obs_q.pop_front(); n_bad++;
                $display("FAIL reset_mid_trig: unexpected event kind=%0d at=%0d", o.kind, o.at);
            end else if (obs_q.size() == 0) begin
                e = exp_q.pop_front(); n_bad++;
                $display("FAIL reset_mid_trig: missing event kind=%0d at=%0d", e.kind, e.at);
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL reset_mid_trig: observed kind=%0d at=%0d expected kind=%0d at=%0d",
                             o.kind, o.at, e.kind, e.at);
                end
            end
        end
    endtask

    task automatic test_collision;
        int unsigned n;
        ev_t e, o;
        @(negedge clk);
        exp_q.delete(); obs_q.delete();
        n = cyc + 1;
        start = 1'b1;
        expect_ev(EV_TRIG_RISE, n + 1);
        expect_ev(EV_TRIG_FALL, n + 1 + TRIG_CYC);
        expect_ev(EV_ECHO_RISE, n + 53);
        expect_ev(EV_DONE,      n + 1 + TRIG_CYC + TO_CYC);
        expect_ev(EV_BUSY_FALL, n + PER_CYC);
        wait_until(n);      start = 1'b0;
        wait_until(n + 50); echo = 1'b1;
        // Synchronized fall lands on the cycle the phase count hits TO_CYC.
        wait_until(n + 1 + TRIG_CYC + TO_CYC - 3); echo = 1'b0;
        wait_until(n + PER_CYC + 10);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                o = obs_q.pop_front(); n_bad++;
                $display("FAIL collision: unexpected event kind=%0d at=%0d", o.kind, o.at);
            end else if (obs_q.size() == 0) begin
                e = exp_q.pop_front(); n_bad++;
                $display("FAIL collision: missing event kind=%0d at=%0d", e.kind, e.at);
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL collision: observed kind=%0d at=%0d expected kind=%0d at=%0d",
                             o.kind, o.at, e.kind, e.at);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_shot();
        test_no_echo(1'b0);
        test_no_echo(1'b1);
        test_continuous();
        test_reset_mid_trig();
        test_collision();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
